// File: rtl/snap_vacc_pkg.sv
// Shared types and bit positions for the vacc3 snapshot capture controller.
package snap_vacc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } snap_state_e;

  // ctrl_in bit positions
  localparam int unsigned CTRL_ARM  = 0;
  localparam int unsigned CTRL_IMM  = 1;
  localparam int unsigned CTRL_ALLV = 2;
  localparam int unsigned CTRL_CIRC = 3;

  // addr_out status bit positions
  localparam int unsigned STAT_DONE = 31;
  localparam int unsigned STAT_BUSY = 30;
  localparam int unsigned STAT_WRAP = 29;

  localparam int unsigned STAT_W = 32;

endpackage

// File: rtl/snap_edge_det.sv
// Registered-copy edge detector; rise/fall are combinational against the stored copy.
module snap_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign rise_c_o = d_i & ~d_q;
  assign fall_c_o = ~d_i & d_q;

endmodule

// File: rtl/snap_vacc_capture_ctrl.sv
// vacc3 snapshot capture controller: arm, trigger, write samples to BRAM, report status.
// Optional circular capture mode is enabled by defining SNAP_VACC_CIRC_EN.
module snap_vacc_capture_ctrl
  import snap_vacc_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_in,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       addr_out,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  snap_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_data_q, bram_data_d;
  logic              bram_we_q, bram_we_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              wrap_q, wrap_d;

  logic arm_rise_c;
  logic arm_fall_c;
  logic ev_c;
  logic fire_c;
  logic wr_c;
  logic circ_c;

  snap_edge_det u_arm_edge (
    .clk_i    (user_clk),
    .rst_i    (user_rst),
    .d_i      (ctrl_in[CTRL_ARM]),
    .rise_c_o (arm_rise_c),
    .fall_c_o (arm_fall_c)
  );

  assign ev_c   = din_valid | ctrl_in[CTRL_ALLV];
  assign fire_c = trig | ctrl_in[CTRL_IMM];

`ifdef SNAP_VACC_CIRC_EN
  assign circ_c = ctrl_in[CTRL_CIRC];
`else
  assign circ_c = 1'b0;
`endif

  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, ctrl_in[31:4], ctrl_in[CTRL_CIRC], arm_fall_c};

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      bram_we_q   <= 1'b0;
      stat_q      <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
      bram_we_q   <= bram_we_d;
      stat_q      <= stat_d;
      wrap_q      <= wrap_d;
    end
  end

  // Next state, write issue and status word; arm edge overrides everything.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    bram_addr_d = bram_addr_q;
    bram_data_d = bram_data_q;
    bram_we_d   = 1'b0;
    wrap_d      = wrap_q;
    wr_c        = 1'b0;
    stat_d      = '0;

    if (arm_rise_c) begin
      state_d  = ARMED;
      wr_ptr_d = '0;
      wrap_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (fire_c) begin
            state_d = CAPTURE;
            if (ev_c) begin
              wr_c     = 1'b1;
              wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
          end
        end
        CAPTURE: begin
          if (ev_c) begin
            wr_c     = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (wr_ptr_q == PTR_MAX) begin
              if (circ_c) wrap_d  = 1'b1;
              else        state_d = DONE;
            end
          end
`ifdef SNAP_VACC_CIRC_EN
          if (circ_c && arm_fall_c) state_d = DONE;
`endif
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end

    if (wr_c) begin
      bram_we_d   = 1'b1;
      bram_addr_d = wr_ptr_q;
      bram_data_d = din;
    end

    // Last-written address survives non-write cycles, cleared by arm.
    if (wr_c)            stat_d[ADDR_W-1:0] = wr_ptr_q;
    else if (!arm_rise_c) stat_d[ADDR_W-1:0] = stat_q[ADDR_W-1:0];
    stat_d[STAT_DONE] = (state_d == DONE);
    stat_d[STAT_BUSY] = (state_d == ARMED) || (state_d == CAPTURE);
    stat_d[STAT_WRAP] = wrap_d;
  end

  assign bram_addr = bram_addr_q;
  assign bram_data = bram_data_q;
  assign bram_we   = bram_we_q;
  assign addr_out  = stat_q;
  assign done      = stat_q[STAT_DONE];

endmodule

// File: tb/tb_snap_vacc_capture_ctrl.sv
// Directed self-checking bench for snap_vacc_capture_ctrl with ADDR_W=4.
module tb_snap_vacc_capture_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic [31:0]       ctrl_in;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              trig;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       addr_out;
  logic              done;

  int n_chk = 0;
  int n_err = 0;

  snap_vacc_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk  (user_clk),
    .user_rst  (user_rst),
    .ctrl_in   (ctrl_in),
    .din       (din),
    .din_valid (din_valid),
    .trig      (trig),
    .bram_addr (bram_addr),
    .bram_data (bram_data),
    .bram_we   (bram_we),
    .addr_out  (addr_out),
    .done      (done)
  );

  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  // Cycle with no BRAM write expected.
  task automatic exp_nowr(input string tag, input logic [31:0] stat);
    check({tag, ".we"},   32'(bram_we), 32'd0);
    check({tag, ".stat"}, addr_out, stat);
    check({tag, ".done"}, 32'(done), 32'(stat[31]));
  endtask

  // Cycle with a BRAM write expected.
  task automatic exp_wr(input string tag, input int a, input logic [31:0] d,
                        input logic [31:0] stat);
    check({tag, ".we"},   32'(bram_we), 32'd1);
    check({tag, ".addr"}, 32'(bram_addr), 32'(a));
    check({tag, ".data"}, bram_data, d);
    check({tag, ".stat"}, addr_out, stat);
    check({tag, ".done"}, 32'(done), 32'(stat[31]));
  endtask

  initial begin
    user_rst  = 1'b1;
    ctrl_in   = 32'h0;
    din       = 32'h0;
    din_valid = 1'b0;
    trig      = 1'b0;

    // reset state, then idle with toggling data
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      tick();
      exp_nowr("rst", 32'h0);
      check("rst.addr", 32'(bram_addr), 32'h0);
      check("rst.data", bram_data, 32'h0);
    end
    user_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din       = (i % 2 == 0) ? 32'hFFFF_0000 : 32'h0000_FFFF;
      din_valid = 1'b1;
      tick();
      exp_nowr("idle", 32'h0);
    end

    // arm + immediate, full linear capture
    din_valid = 1'b0;
    ctrl_in   = 32'h3;
    tick();
    exp_nowr("t2.arm", 32'h4000_0000);
    for (int k = 0; k < 16; k++) begin
      din       = 32'(k);
      din_valid = 1'b1;
      tick();
      exp_wr("t2.wr", k, 32'(k), (k == 15) ? 32'h8000_000F : (32'h4000_0000 | 32'(k)));
    end
    din_valid = 1'b0;
    tick();
    exp_nowr("t2.end", 32'h8000_000F);

    // overflow: 20 samples yields exactly 16 writes
    ctrl_in = 32'h0;
    tick();
    exp_nowr("t4.drop", 32'h8000_000F);
    ctrl_in = 32'h3;
    tick();
    exp_nowr("t4.arm", 32'h4000_0000);
    for (int k = 0; k < 20; k++) begin
      din       = 32'h100 + 32'(k);
      din_valid = 1'b1;
      tick();
      if (k < 16) begin
        exp_wr("t4.wr", k, 32'h100 + 32'(k), (k == 15) ? 32'h8000_000F : (32'h4000_0000 | 32'(k)));
      end else begin
        exp_nowr("t4.over", 32'h8000_000F);
        check("t4.hold_addr", 32'(bram_addr), 32'hF);
      end
    end

    // external trigger with valid gaps
    din_valid = 1'b0;
    ctrl_in   = 32'h0;
    tick();
    ctrl_in = 32'h1;
    tick();
    exp_nowr("t3.arm", 32'h4000_0000);
    din = 32'h11; din_valid = 1'b1; trig = 1'b0; tick();
    exp_nowr("t3.notrig", 32'h4000_0000);
    din = 32'h55; din_valid = 1'b1; trig = 1'b1; tick();
    exp_wr("t3.first", 0, 32'h55, 32'h4000_0000);
    din = 32'h66; din_valid = 1'b0; trig = 1'b0; tick();
    exp_nowr("t3.gap", 32'h4000_0000);
    check("t3.hold_data", bram_data, 32'h55);
    din = 32'h77; din_valid = 1'b1; tick();
    exp_wr("t3.wr1", 1, 32'h77, 32'h4000_0001);
    din = 32'h78; din_valid = 1'b0; trig = 1'b1; tick();
    exp_nowr("t3.gap2", 32'h4000_0001);
    din = 32'h88; din_valid = 1'b1; trig = 1'b0; tick();
    exp_wr("t3.wr2", 2, 32'h88, 32'h4000_0002);

    // re-arm mid-capture after 7 writes
    din_valid = 1'b0;
    ctrl_in   = 32'h0;
    tick();
    exp_nowr("t5.drop0", 32'h4000_0002);
    ctrl_in = 32'h3;
    tick();
    exp_nowr("t5.arm", 32'h4000_0000);
    for (int k = 0; k < 7; k++) begin
      din       = 32'h200 + 32'(k);
      din_valid = 1'b1;
      tick();
      exp_wr("t5.wr", k, 32'h200 + 32'(k), 32'h4000_0000 | 32'(k));
    end
    din_valid = 1'b0;
    ctrl_in   = 32'h2;
    tick();
    exp_nowr("t5.drop", 32'h4000_0006);
    ctrl_in = 32'h3;
    tick();
    exp_nowr("t5.rearm", 32'h4000_0000);
    din = 32'hAB; din_valid = 1'b1; tick();
    exp_wr("t5.restart", 0, 32'hAB, 32'h4000_0000);
    din = 32'hCD; din_valid = 1'b0; ctrl_in = 32'h7; tick();
    exp_wr("t5.allv", 1, 32'hCD, 32'h4000_0001);

    // reset mid-capture aborts
    user_rst = 1'b1; din_valid = 1'b1; tick();
    exp_nowr("rstmid", 32'h0);
    user_rst = 1'b0; ctrl_in = 32'h0; tick();
    exp_nowr("rstmid.idle", 32'h0);

    // held trigger fires the cycle after arm, not in the arm cycle
    ctrl_in = 32'h1; trig = 1'b1; din = 32'h99; din_valid = 1'b1; tick();
    exp_nowr("held.arm", 32'h4000_0000);
    din = 32'h9A; tick();
    exp_wr("held.fire", 0, 32'h9A, 32'h4000_0000);
    trig = 1'b0; din_valid = 1'b0; ctrl_in = 32'h0; tick();
    exp_nowr("held.drop", 32'h4000_0000);

`ifdef SNAP_VACC_CIRC_EN
    // circular capture stopped by arm falling
    ctrl_in = 32'hB;
    tick();
    exp_nowr("t6.arm", 32'h4000_0000);
    for (int k = 0; k < 20; k++) begin
      din       = 32'h300 + 32'(k);
      din_valid = 1'b1;
      tick();
      exp_wr("t6.wr", k % 16, 32'h300 + 32'(k),
             32'h4000_0000 | ((k >= 15) ? 32'h2000_0000 : 32'h0) | 32'(k % 16));
    end
    din_valid = 1'b0;
    ctrl_in   = 32'hA;
    tick();
    exp_nowr("t6.stop", 32'hA000_0003);
    din_valid = 1'b1;
    tick();
    exp_nowr("t6.hold", 32'hA000_0003);
`else
    // circular bit ignored: capture stops at full
    ctrl_in = 32'hB;
    tick();
    exp_nowr("t6.arm", 32'h4000_0000);
    for (int k = 0; k < 17; k++) begin
      din       = 32'h300 + 32'(k);
      din_valid = 1'b1;
      tick();
      if (k < 16)
        exp_wr("t6.wr", k, 32'h300 + 32'(k), (k == 15) ? 32'h8000_000F : (32'h4000_0000 | 32'(k)));
      else
        exp_nowr("t6.full", 32'h8000_000F);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
